// File: rtl/mem_bridge.sv
// mem_bridge: arbitrates an instruction-fetch port and a data port onto a
// single-outstanding memory interface. Handles RV32I load/store widths,
// lane steering, sign extension and misaligned/illegal access errors.
module mem_bridge #(
    parameter int ADDR_W        = 32,
    parameter int MEM_LATENCY   = 1,
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    // instruction port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    // memory side
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              last_q;      // 1 = data port was granted most recently
    logic              owner_q;     // 1 = data port owns the transaction
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic [3:0]        be_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wd_q;

    logic              any_req;
    logic              pick;        // winner: 1 = data, 0 = instruction
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_f3;
    logic              sel_we;
    logic              legal;
    logic              misal;
    logic              bad;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wd;

    // Load data formatting: lane select then sign/zero extend; stores return 0.
    function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [2:0] f3,
                                             input logic [1:0] lo, input logic we);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        if (we) return 32'd0;
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    // Arbitration and decode of the winning request (fetch is a word load).
    always_comb begin
        any_req = if_req | d_req;
        if (if_req && d_req) pick = DATA_PRIORITY ? 1'b1 : !last_q;
        else                 pick = d_req;
        sel_addr = pick ? d_addr : if_addr;
        sel_f3   = pick ? d_funct3 : 3'b010;
        sel_we   = pick & d_we;
        case (sel_f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !sel_we;
            default:                legal = 1'b0;
        endcase
        case (sel_f3[1:0])
            2'b01:   misal = sel_addr[0];
            2'b10:   misal = (sel_addr[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
        bad = !legal || misal;
        case (sel_f3[1:0])
            2'b00:   sel_be = 4'b0001 << sel_addr[1:0];
            2'b01:   sel_be = sel_addr[1] ? 4'b1100 : 4'b0011;
            default: sel_be = 4'b1111;
        endcase
        case (sel_f3[1:0])
            2'b00:   sel_wd = {4{d_wdata[7:0]}};
            2'b01:   sel_wd = {2{d_wdata[15:0]}};
            default: sel_wd = d_wdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and all FSM-qualified outputs.
    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_err    = 1'b0;
        d_err     = 1'b0;
        if_rdata  = 32'd0;
        d_rdata   = 32'd0;
        mem_wen   = 1'b0;
        mem_be    = 4'd0;
        case (state_q)
            IDLE: begin
                if (any_req && !rst) begin
                    if_gnt  = !pick;
                    d_gnt   = pick;
                    state_d = bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_wen = we_q;
                mem_be  = be_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP: begin
                if_rvalid = !owner_q;
                d_rvalid  = owner_q;
                if_err    = !owner_q & err_q;
                d_err     = owner_q & err_q;
                if_rdata  = owner_q ? 32'd0 : rdata_q;
                d_rdata   = owner_q ? rdata_q : 32'd0;
                state_d   = IDLE;
            end
        endcase
    end

    // Request capture, latency counter and response data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            lo_q       <= 2'd0;
            be_q       <= 4'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            mem_addr_q <= '0;
            mem_wd_q   <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= pick;
                        last_q  <= pick;
                        we_q    <= sel_we;
                        f3_q    <= sel_f3;
                        lo_q    <= sel_addr[1:0];
                        be_q    <= sel_be;
                        err_q   <= bad;
                        rdata_q <= 32'd0;
                        if (!bad) begin
                            mem_addr_q <= {sel_addr[ADDR_W-1:2], 2'b00};
                            mem_wd_q   <= sel_wd;
                        end
                    end
                end
                ISSUE: cnt_q <= LAT;
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) rdata_q <= fmt_load(mem_rd, f3_q, lo_q, we_q);
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: default instance (latency 1, data priority),
// a round-robin instance and a latency-4 instance share the same stimulus.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [2:0]  d_funct3 = 3'd0;
    logic [31:0] mem_rd = 32'd0;

    int errors = 0;
    int checks = 0;

    logic        a_if_gnt, a_if_rvalid, a_if_err, a_d_gnt, a_d_rvalid, a_d_err, a_mem_wen;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wd;
    logic [3:0]  a_mem_be;
    logic        b_if_gnt, b_if_rvalid, b_if_err, b_d_gnt, b_d_rvalid, b_d_err, b_mem_wen;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wd;
    logic [3:0]  b_mem_be;
    logic        c_if_gnt, c_if_rvalid, c_if_err, c_d_gnt, c_d_rvalid, c_d_err, c_mem_wen;
    logic [31:0] c_if_rdata, c_d_rdata, c_mem_addr, c_mem_wd;
    logic [3:0]  c_mem_be;

    always #5 clk = ~clk;

    mem_bridge #(.ADDR_W(32), .MEM_LATENCY(1), .DATA_PRIORITY(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
        .if_rdata(a_if_rdata), .if_err(a_if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata), .d_err(a_d_err),
        .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wd(a_mem_wd), .mem_be(a_mem_be),
        .mem_rd(mem_rd)
    );

    mem_bridge #(.ADDR_W(32), .MEM_LATENCY(1), .DATA_PRIORITY(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .if_err(b_if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .d_err(b_d_err),
        .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .mem_be(b_mem_be),
        .mem_rd(mem_rd)
    );

    mem_bridge #(.ADDR_W(32), .MEM_LATENCY(4), .DATA_PRIORITY(1'b1)) u_lat4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(c_if_gnt), .if_rvalid(c_if_rvalid),
        .if_rdata(c_if_rdata), .if_err(c_if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(c_d_gnt), .d_rvalid(c_d_rvalid), .d_rdata(c_d_rdata), .d_err(c_d_err),
        .mem_wen(c_mem_wen), .mem_addr(c_mem_addr), .mem_wd(c_mem_wd), .mem_be(c_mem_be),
        .mem_rd(mem_rd)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_addr = 32'h88;
        d_wdata = 32'hFFFF_FFFF; d_we = 1'b1; d_funct3 = 3'b010;
        #1;
        checks++;
        if ({a_if_gnt, a_d_gnt, b_if_gnt, b_d_gnt} !== 4'b0) begin
            errors++; $display("FAIL reset_gnt got=%b exp=0000", {a_if_gnt, a_d_gnt, b_if_gnt, b_d_gnt});
        end
        checks++;
        if ({a_if_rvalid, a_d_rvalid, a_if_err, a_d_err, a_mem_wen, a_mem_be} !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0",
                {a_if_rvalid, a_d_rvalid, a_if_err, a_d_err, a_mem_wen, a_mem_be});
        end
        checks++;
        if ({a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wd} !== 128'd0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wd});
        end
        $display("txn reset checked");
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        mem_rd = 32'h0050_0093; if_addr = 32'h10; if_req = 1'b1;
        #1;
        checks++;
        if ({a_if_gnt, a_d_gnt} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt got=%b exp=10", {a_if_gnt, a_d_gnt});
        end
        @(negedge clk); if_req = 1'b0; #1;
        checks++;
        if (a_mem_addr !== 32'h10 || a_mem_wen !== 1'b0 || a_mem_be !== 4'hF || a_if_gnt !== 1'b0) begin
            errors++; $display("FAIL fetch_issue got addr=%h wen=%b be=%b gnt=%b exp addr=10 wen=0 be=1111 gnt=0",
                a_mem_addr, a_mem_wen, a_mem_be, a_if_gnt);
        end
        @(negedge clk); #1;
        checks++;
        if (a_if_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_early_rvalid got=%b exp=0", a_if_rvalid);
        end
        @(negedge clk); #1;
        checks++;
        if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'h0050_0093 || a_if_err !== 1'b0 || a_d_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_resp got rv=%b rdata=%h err=%b drv=%b exp rv=1 rdata=00500093 err=0 drv=0",
                a_if_rvalid, a_if_rdata, a_if_err, a_d_rvalid);
        end
        $display("txn fetch addr=%h rdata=%h", 32'h10, a_if_rdata);
        @(negedge clk); #1;
        checks++;
        if (a_if_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_rvalid_pulse got=%b exp=0", a_if_rvalid);
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] ad  [3] = '{32'h103, 32'h102, 32'h104};
        logic [31:0] wd  [3] = '{32'h0000_00AB, 32'h0000_1234, 32'hDEAD_BEEF};
        logic [3:0]  ebe [3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] ewd [3] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF};
        logic [31:0] ead [3] = '{32'h100, 32'h100, 32'h104};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b1; d_funct3 = f3[i]; d_addr = ad[i]; d_wdata = wd[i];
            #1;
            checks++;
            if (a_d_gnt !== 1'b1) begin
                errors++; $display("FAIL store%0d_gnt got=%b exp=1", i, a_d_gnt);
            end
            @(negedge clk); d_req = 1'b0; #1;
            checks++;
            if (a_mem_wen !== 1'b1 || a_mem_be !== ebe[i] || a_mem_wd !== ewd[i] || a_mem_addr !== ead[i]) begin
                errors++; $display("FAIL store%0d_issue got wen=%b be=%b wd=%h addr=%h exp wen=1 be=%b wd=%h addr=%h",
                    i, a_mem_wen, a_mem_be, a_mem_wd, a_mem_addr, ebe[i], ewd[i], ead[i]);
            end
            @(negedge clk); #1;
            checks++;
            if (a_mem_wen !== 1'b0 || a_mem_be !== 4'd0 || a_mem_wd !== ewd[i]) begin
                errors++; $display("FAIL store%0d_wait got wen=%b be=%b wd=%h exp wen=0 be=0000 wd=%h",
                    i, a_mem_wen, a_mem_be, a_mem_wd, ewd[i]);
            end
            @(negedge clk); #1;
            checks++;
            if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'd0 || a_d_err !== 1'b0 || a_if_rvalid !== 1'b0) begin
                errors++; $display("FAIL store%0d_resp got rv=%b rdata=%h err=%b irv=%b exp rv=1 rdata=0 err=0 irv=0",
                    i, a_d_rvalid, a_d_rdata, a_d_err, a_if_rvalid);
            end
            $display("txn store f3=%b addr=%h wd=%h", f3[i], ad[i], ewd[i]);
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
        logic [31:0] ad [6] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
        logic [31:0] ex [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h0000_007F, 32'h80FF_7F01};
        mem_rd = 32'h80FF_7F01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b0; d_funct3 = f3[i]; d_addr = ad[i];
            #1;
            checks++;
            if (a_d_gnt !== 1'b1) begin
                errors++; $display("FAIL load%0d_gnt got=%b exp=1", i, a_d_gnt);
            end
            @(negedge clk); d_req = 1'b0; #1;
            checks++;
            if (a_mem_wen !== 1'b0 || a_mem_addr !== 32'h100) begin
                errors++; $display("FAIL load%0d_issue got wen=%b addr=%h exp wen=0 addr=100", i, a_mem_wen, a_mem_addr);
            end
            @(negedge clk); @(negedge clk); #1;
            checks++;
            if (a_d_rvalid !== 1'b1 || a_d_rdata !== ex[i] || a_d_err !== 1'b0) begin
                errors++; $display("FAIL load%0d_resp got rv=%b rdata=%h err=%b exp rv=1 rdata=%h err=0",
                    i, a_d_rvalid, a_d_rdata, a_d_err, ex[i]);
            end
            $display("txn load f3=%b addr=%h rdata=%h", f3[i], ad[i], a_d_rdata);
        end
    endtask

    task automatic test_error();
        logic        we [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b100, 3'b111};
        logic [31:0] ad [6] = '{32'h202, 32'h201, 32'h203, 32'h200, 32'h200, 32'h200};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d_req = 1'b1; d_we = we[i]; d_funct3 = f3[i]; d_addr = ad[i]; d_wdata = 32'h5A5A_5A5A;
            #1;
            checks++;
            if (a_d_gnt !== 1'b1 || a_mem_wen !== 1'b0 || a_mem_be !== 4'd0) begin
                errors++; $display("FAIL err%0d_gnt got gnt=%b wen=%b be=%b exp gnt=1 wen=0 be=0000",
                    i, a_d_gnt, a_mem_wen, a_mem_be);
            end
            @(negedge clk); d_req = 1'b0; #1;
            checks++;
            if (a_d_rvalid !== 1'b1 || a_d_err !== 1'b1 || a_d_rdata !== 32'd0 || a_mem_wen !== 1'b0 ||
                a_mem_be !== 4'd0 || a_if_rvalid !== 1'b0 || a_mem_addr !== 32'h100) begin
                errors++; $display("FAIL err%0d_resp got rv=%b err=%b rdata=%h wen=%b be=%b irv=%b addr=%h exp rv=1 err=1 rdata=0 wen=0 be=0 irv=0 addr=100",
                    i, a_d_rvalid, a_d_err, a_d_rdata, a_mem_wen, a_mem_be, a_if_rvalid, a_mem_addr);
            end
            $display("txn error we=%b f3=%b addr=%h", we[i], f3[i], ad[i]);
            @(negedge clk); #1;
            checks++;
            if (a_d_rvalid !== 1'b0 || a_d_err !== 1'b0) begin
                errors++; $display("FAIL err%0d_after got rv=%b err=%b exp 0 0", i, a_d_rvalid, a_d_err);
            end
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h12;
        #1;
        checks++;
        if (a_if_gnt !== 1'b1) begin
            errors++; $display("FAIL ferr_gnt got=%b exp=1", a_if_gnt);
        end
        @(negedge clk); if_req = 1'b0; #1;
        checks++;
        if (a_if_rvalid !== 1'b1 || a_if_err !== 1'b1 || a_if_rdata !== 32'd0 || a_d_rvalid !== 1'b0 || a_d_err !== 1'b0) begin
            errors++; $display("FAIL ferr_resp got rv=%b err=%b rdata=%h drv=%b derr=%b exp 1 1 0 0 0",
                a_if_rvalid, a_if_err, a_if_rdata, a_d_rvalid, a_d_err);
        end
        $display("txn fetch error addr=%h", 32'h12);
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        do_reset();
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h40;
        mem_rd = 32'h5555_AAAA;
        for (int k = 0; k < 4; k++) begin
            logic ei, ed;
            ei = (k % 2 == 0);
            ed = !ei;
            #1;
            checks++;
            if ({b_if_gnt, b_d_gnt} !== {ei, ed} || {a_if_gnt, a_d_gnt} !== 2'b01) begin
                errors++; $display("FAIL arb%0d_gnt got rr=%b%b prio=%b%b exp rr=%b%b prio=01",
                    k, b_if_gnt, b_d_gnt, a_if_gnt, a_d_gnt, ei, ed);
            end
            @(negedge clk); #1;
            checks++;
            if (b_mem_addr !== (ei ? 32'h20 : 32'h40) || {b_if_gnt, b_d_gnt} !== 2'b00) begin
                errors++; $display("FAIL arb%0d_issue got addr=%h gnt=%b%b exp addr=%h gnt=00",
                    k, b_mem_addr, b_if_gnt, b_d_gnt, ei ? 32'h20 : 32'h40);
            end
            @(negedge clk); @(negedge clk); #1;
            checks++;
            if ({b_if_rvalid, b_d_rvalid} !== {ei, ed} || b_if_rdata !== (ei ? 32'h5555_AAAA : 32'd0)) begin
                errors++; $display("FAIL arb%0d_resp got rv=%b%b irdata=%h exp rv=%b%b",
                    k, b_if_rvalid, b_d_rvalid, b_if_rdata, ei, ed);
            end
            $display("txn arbitration round %0d rr_owner=%s", k, ei ? "I" : "D");
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen_rv, seen_wen;
        int   lat;
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h80; mem_rd = 32'h1122_3344;
        #1;
        checks++;
        if (c_d_gnt !== 1'b1) begin
            errors++; $display("FAIL mid_gnt got=%b exp=1", c_d_gnt);
        end
        @(negedge clk); d_req = 1'b0; #1;
        checks++;
        if (c_mem_addr !== 32'h80) begin
            errors++; $display("FAIL mid_issue got addr=%h exp=80", c_mem_addr);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({c_mem_addr, c_mem_wd, c_d_rdata} !== 96'd0 ||
            {c_mem_be, c_mem_wen, c_d_rvalid, c_d_err, c_d_gnt, c_if_rvalid} !== 9'd0) begin
            errors++; $display("FAIL mid_rst_outputs got addr=%h wd=%h be=%b wen=%b drv=%b exp all 0",
                c_mem_addr, c_mem_wd, c_mem_be, c_mem_wen, c_d_rvalid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_rv = 1'b0; seen_wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            seen_rv  = seen_rv | c_d_rvalid | c_if_rvalid;
            seen_wen = seen_wen | c_mem_wen;
        end
        checks++;
        if (seen_rv !== 1'b0 || seen_wen !== 1'b0) begin
            errors++; $display("FAIL mid_aborted got rvalid_seen=%b wen_seen=%b exp 0 0", seen_rv, seen_wen);
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h30; mem_rd = 32'hCAFE_F00D;
        #1;
        checks++;
        if (c_if_gnt !== 1'b1) begin
            errors++; $display("FAIL mid_next_gnt got=%b exp=1", c_if_gnt);
        end
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk); if_req = 1'b0; #1;
            if (c_if_rvalid === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        checks++;
        if (lat != 6 || c_if_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL mid_next_resp got latency=%0d rdata=%h exp latency=6 rdata=cafef00d", lat, c_if_rdata);
        end
        $display("txn post-reset fetch latency=%0d rdata=%h", lat, c_if_rdata);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_error();
        test_arbitration();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of both ports and memory side.
REQ-002 SHALL have parameter MEM_LATENCY, default 1, range 1..15: cycles from memory issue cycle to mem_rd valid.
REQ-003 SHALL have parameter DATA_PRIORITY, default 1: 1 = data port always wins, 0 = round-robin between ports.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-005 SHALL have instruction-port ports: if_req  in  1  fetch request; if_addr  in  ADDR_W  fetch address; if_gnt  out  1  request accepted; if_rvalid  out  1  response pulse; if_rdata  out  32  fetched word; if_err  out  1  error with response.
REQ-006 SHALL have data-port ports: d_req  in  1; d_we  in  1  1 = store; d_addr  in  ADDR_W; d_wdata  in  32; d_funct3  in  3  RV32I load/store width code; d_gnt  out  1; d_rvalid  out  1; d_rdata  out  32; d_err  out  1.
REQ-007 SHALL have memory-side ports: mem_wen  out  1  write strobe; mem_addr  out  ADDR_W  word-aligned address; mem_wd  out  32  write data; mem_be  out  4  byte enables; mem_rd  in  32  read data.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at a time.
REQ-009 In IDLE with any req high, SHALL assert the winner's gnt combinationally that cycle, capture its request at the edge, and go to ISSUE (or to RESP if erroneous).
REQ-010 Arbitration: DATA_PRIORITY=1 -> d_req wins on tie; DATA_PRIORITY=0 -> on tie, port not granted last wins; single requester always wins.
REQ-011 gnt SHALL be high only in IDLE and for at most one port; requesters hold req/inputs until gnt; req dropped before gnt creates no transaction.
REQ-012 ISSUE (one cycle): drive mem_addr = {addr[ADDR_W-1:2],2'b00}, mem_be, mem_wd; mem_wen = 1 only for stores and only in ISSUE; go to WAIT with counter = MEM_LATENCY.
REQ-013 WAIT: decrement counter each cycle; in the cycle counter equals 1, latch formatted mem_rd and go to RESP.
REQ-014 RESP (one cycle): pulse owner's rvalid with registered rdata/err; then IDLE; response arrives MEM_LATENCY+2 cycles after gnt cycle.
REQ-015 Outside ISSUE, mem_wen and mem_be SHALL be 0; mem_addr/mem_wd hold last value.
REQ-016 Stores: SB (000) mem_be = 1<<addr[1:0], byte replicated in all 4 lanes; SH (001) be = 0011/1100 by addr[1], halfword replicated; SW (010) be = 1111.
REQ-017 Loads: LB(000)/LH(001) sign-extend, LBU(100)/LHU(101) zero-extend, selected lane by addr[1:0]; LW(010) full word; store response d_rdata = 0.
REQ-018 Fetch: always word access, if_rdata = mem_rd.
REQ-019 Error: misaligned (half with addr[0]=1, word/fetch with addr[1:0]!=0) or illegal funct3 (011,110,111, or load/store codes invalid for d_we) SHALL skip ISSUE/WAIT, no memory access, RESP next cycle with err=1, rdata=0.
REQ-020 rvalid/err SHALL never assert for the non-owning port.

Reset
REQ-021 rst high SHALL immediately force state IDLE, counter 0, all outputs 0 (gnt, rvalid, err, rdata, mem_wen, mem_be, mem_addr, mem_wd).
REQ-022 Reset mid-transaction SHALL abort it: no rvalid issued, no mem_wen after assertion.
REQ-023 Round-robin pointer SHALL reset so instruction port wins first tie.

Verification
REQ-024 Fetch if_addr=0x10, MEM_LATENCY=1, mem_rd=0x00500093 -> if_gnt cycle 0, mem_addr=0x10 cycle 1, if_rvalid with if_rdata=0x00500093 cycle 3.
REQ-025 SB d_addr=0x103, d_wdata=0xAB -> in ISSUE mem_wen=1, mem_be=1000, mem_wd=0xABABABAB, mem_addr=0x100; d_rvalid, d_rdata=0.
REQ-026 LB d_addr=0x102, mem_rd=0x80FF7F01 -> d_rdata=0xFFFFFFFF; LBU same -> 0x000000FF; LH 0x102 -> 0xFFFF80FF.
REQ-027 LW d_addr=0x102 -> d_err=1, d_rvalid one cycle after gnt, mem_wen=0, mem_be=0 throughout.
REQ-028 Both req held, DATA_PRIORITY=0 -> grants alternate I,D,I,D; DATA_PRIORITY=1 -> D every time.
REQ-029 MEM_LATENCY=4, rst asserted during WAIT -> outputs 0 same cycle, no rvalid, next request served normally with rvalid 6 cycles after gnt.
